// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C byte transmitter.
package i2c_pkg;

  localparam int   BYTE_W      = 8;
  localparam int   CNT_W       = 3;
  localparam logic SDA_RELEASE = 1'b1;

  // Byte transmitter state machine
  typedef enum logic [2:0] {
    IDLE,
    WAIT_FALL,
    SHIFT,
    ACK_REL,
    ACK_SAMPLE,
    DONE
  } tx_state_e;

  // Bit counter decrement that holds at zero instead of wrapping
  function automatic logic [CNT_W-1:0] cnt_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? '0 : c - 1'b1;
  endfunction

endpackage

// File: rtl/scl_edge_detect.sv
// Registers the divider's SCL level and flags its falling and rising edges.
module scl_edge_detect (
  input  logic clk,
  input  logic rst_,
  input  logic scl_in,
  output logic fall,
  output logic rise
);

  logic scl_q;

  // One-cycle history of SCL; resets high to match an idle bus
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      scl_q <= 1'b1;
    end else begin
      scl_q <= scl_in;
    end
  end

  assign fall = scl_q & ~scl_in;
  assign rise = ~scl_q & scl_in;

endmodule

// File: rtl/i2c_byte_tx.sv
// Transmits one byte MSB first on SDA, aligned to SCL falling edges, then
// releases SDA for the ACK bit and reports ACK/NACK.
module i2c_byte_tx
  import i2c_pkg::*;
(
  input  logic              clk,
  input  logic              rst_,
  input  logic              enable,
  input  logic              scl_in,
  input  logic              start_done,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              sda_in,
  output logic              sda_out,
  output logic              busy,
  output logic              byte_done,
  output logic              ack_ok,
  output logic              nack
);

  logic fall;
  logic rise;

  tx_state_e         state_q;
  logic [BYTE_W-1:0] shift_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              session_q;
  logic              sda_out_q;
  logic              busy_q;
  logic              byte_done_q;
  logic              ack_ok_q;
  logic              nack_q;

  scl_edge_detect u_scl_edge (
    .clk    (clk),
    .rst_   (rst_),
    .scl_in (scl_in),
    .fall   (fall),
    .rise   (rise)
  );

  // Ready only from registered state, so a start_done arriving together with
  // tx_valid cannot be accepted in that same cycle.
  assign tx_ready = (state_q == IDLE) & session_q & enable;

  // Byte FSM plus datapath. SDA is only ever updated on the cycle after an
  // SCL fall, which keeps data stable while SCL is high.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      session_q   <= 1'b0;
      sda_out_q   <= SDA_RELEASE;
      busy_q      <= 1'b0;
      byte_done_q <= 1'b0;
      ack_ok_q    <= 1'b0;
      nack_q      <= 1'b0;
    end else if (!enable) begin
      // Abort: release the bus and drop the session without completing
      state_q     <= IDLE;
      cnt_q       <= '0;
      session_q   <= 1'b0;
      sda_out_q   <= SDA_RELEASE;
      busy_q      <= 1'b0;
      byte_done_q <= 1'b0;
    end else begin
      byte_done_q <= 1'b0;
      if (start_done) begin
        session_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (tx_valid && tx_ready) begin
            shift_q  <= tx_data;
            cnt_q    <= CNT_W'(BYTE_W - 1);
            ack_ok_q <= 1'b0;
            nack_q   <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= WAIT_FALL;
          end
        end

        WAIT_FALL: begin
          if (fall) begin
            sda_out_q <= shift_q[BYTE_W-1];
            state_q   <= SHIFT;
          end
        end

        SHIFT: begin
          if (fall) begin
            if (cnt_q != '0) begin
              // Next bit sits at [BYTE_W-2] before the shift takes effect
              shift_q   <= shift_q << 1;
              sda_out_q <= shift_q[BYTE_W-2];
              cnt_q     <= cnt_dec(cnt_q);
            end else begin
              // Bit 0 has had its full SCL period; hand SDA to the receiver
              sda_out_q <= SDA_RELEASE;
              state_q   <= ACK_REL;
            end
          end
        end

        ACK_REL: begin
          if (rise) begin
            if (sda_in) begin
              nack_q    <= 1'b1;
              session_q <= 1'b0;
            end else begin
              ack_ok_q  <= 1'b1;
            end
            state_q <= ACK_SAMPLE;
          end
        end

        ACK_SAMPLE: begin
          if (fall) begin
            byte_done_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= DONE;
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sda_out   = sda_out_q;
  assign busy      = busy_q;
  assign byte_done = byte_done_q;
  assign ack_ok    = ack_ok_q;
  assign nack      = nack_q;

endmodule

// File: doc/i2c_byte_tx.md
I2C_BYTE_TX -- requirements
Module: i2c_byte_tx

Interface
REQ-001 Clock and reset SHALL be: one clock; reset is asynchronous and active-low. Ports are named clk and rst_.
REQ-002 Ports SHALL be as follows:
- clk  in  1  system clock (50 MHz)
- rst_  in  1  asynchronous active-low reset
- enable  in  1  block enable; low aborts any activity
- scl_in  in  1  free-running bus clock from the divider, synchronous to clk
- start_done  in  1  one-clk pulse from the start generator when START is complete
- tx_data  in  8  byte to transmit
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  byte accepted when tx_valid and tx_ready are both high
- sda_in  in  1  SDA line level, used for ACK
- sda_out  out  1  SDA drive (1 = released/high, 0 = pull low)
- busy  out  1  byte in flight
- byte_done  out  1  one-clk pulse at the end of the ACK bit
- ack_ok  out  1  last byte was ACKed; held until the next byte is accepted
- nack  out  1  last byte was NACKed; held until the next byte is accepted

Function
REQ-003 The block SHALL register scl_in into scl_q.
- fall = scl_q & ~scl_in
- rise = ~scl_q & scl_in
REQ-004 A session flag SHALL be set by start_done and cleared by nack, by enable low, or by reset.
REQ-005 tx_ready SHALL equal (state==IDLE) & session & enable, decoded from registered state only.
REQ-006 The FSM SHALL have states IDLE, WAIT_FALL, SHIFT, ACK_REL, ACK_SAMPLE and DONE.
REQ-007 In IDLE, a handshake SHALL capture tx_data into the shift register, load bit counter = 7, clear ack_ok and nack, set busy, and go to WAIT_FALL.
REQ-008 In WAIT_FALL, on fall, sda_out SHALL take shift[7] on the next clk edge and the FSM SHALL go to SHIFT.
REQ-009 In SHIFT, on each fall, the register SHALL shift left and the next bit SHALL be driven, MSB first.
REQ-010 After bit 0 has been held for one full SCL period, the next fall SHALL set sda_out = 1 and go to ACK_REL.
REQ-011 In ACK_REL, on rise, sda_in SHALL be sampled: 0 sets ack_ok, 1 sets nack. The FSM then goes to ACK_SAMPLE.
REQ-012 In ACK_SAMPLE, on fall, the FSM SHALL go to DONE.
REQ-013 In DONE, byte_done SHALL be high for exactly one clk, busy SHALL drop, and the FSM SHALL return to IDLE.
REQ-014 sda_out SHALL change only in the clk cycle after fall, so data never changes while SCL is high.
REQ-015 If start_done and tx_valid arrive in the same cycle, session SHALL set and acceptance SHALL occur no earlier than the next cycle.
REQ-016 If enable goes low in any state, then on the next clk edge:
- sda_out = 1, busy = 0, session = 0
- FSM returns to IDLE
- no byte_done pulse
REQ-017 tx_valid while session = 0 SHALL be ignored and the data SHALL NOT be captured.
REQ-018 After a NACK, tx_ready SHALL stay low until a new start_done.
REQ-019 A bit count wrap past 0 SHALL NOT occur; the counter saturates at 0 outside SHIFT.

Reset
REQ-020 While rst_ is low, the following SHALL hold immediately and asynchronously:
- sda_out = 1
- tx_ready = 0, busy = 0, byte_done = 0, ack_ok = 0, nack = 0
- session = 0, state = IDLE, shift register = 8'h00, scl_q = 1
REQ-021 Reset deassertion mid-byte SHALL resume in IDLE with no output glitch low on sda_out.

Structure
REQ-022 Package i2c_pkg SHALL hold the FSM state enum, BYTE_W = 8, and SDA_RELEASE = 1'b1.
REQ-023 SCL edge detection SHALL be a sub-module named scl_edge_detect (inputs clk, rst_, scl_in; outputs fall, rise).
REQ-024 The RTL SHALL be one FSM plus a datapath (shift register, 3-bit counter, session and status flags).

Verification (clk period 20 ns, scl_in toggles every 25 clk)
REQ-025 Reset: rst_ low for 5 clk -> sda_out = 1, tx_ready = 0, busy = 0, all flags 0.
REQ-026 Normal byte: start_done pulse, tx_data = 8'hA5, sda_in = 0 in the ACK bit.
- sda_out sequence across SCL low phases: 1,0,1,0,0,1,0,1, then released
- ack_ok = 1
- byte_done high for exactly 1 clk
REQ-027 NACK: tx_data = 8'h3C, sda_in = 1 at the ACK rise.
- nack = 1, session = 0
- tx_ready stays 0 for 200 clk until a new start_done
REQ-028 Abort: enable low after the third data bit -> sda_out = 1 on the next clk, busy = 0, no byte_done.
REQ-029 No session: tx_valid = 1 with 8'h55 and no start_done -> tx_ready = 0, sda_out stays 1.
REQ-030 Back-to-back: 8'h3C then 8'hFF, both ACKed.
- Second byte accepted in the cycle after byte_done.
- Its bit 7 is driven on the first fall after acceptance.
- Every sda_out change falls within an SCL-low phase, checked by assertion.
